cordic_vectoring: RTL and testbench
===================================

Name: cordic_vectoring

Overview:
- Vectoring-mode CORDIC: the inverse of the rotation core.
- Accepts a signed Cartesian vector {x,y} and drives y to zero by N micro-rotations.
- Returns the magnitude, the per-iteration direction bits sigma[N-1:0] and a quadrant flag.
- sigma uses the rotation core's angle-bit convention: bit i = 1 means the rotation core, fed (mag, 0) and these bits, rotates the vector back to the original half-plane.
- Iterative: one micro-rotation per cycle, valid/ready on both sides.

Parameters:
- B, 14, signed width of each input coordinate.
- N, 7, number of micro-rotations; N >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector.
- data_w  in  2*B  {x[2B-1:B], y[B-1:0]}, two's complement.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- mag  out  B+2  unsigned magnitude.
- sigma  out  N  direction bits; bit i belongs to iteration i.
- quad  out  1  1 = input x was negative and the vector was pre-negated.

Behaviour:
- Reset (rst low, async): state IDLE; in_ready=1; out_valid=0; mag=0; sigma=0; quad=0; cnt=0.
- Internal datapath width W=B+2 (2 guard bits); x and y are sign-extended on load.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, load x,y and go to ITER with cnt=0. If x<0, load -x and -y and set quad=1; else quad=0. Negating -2^(B-1) is exact because of the guard bits.
  - ITER, one cycle per cnt (cnt = 0..N-1):
    - d = (y >= 0); sigma[cnt] <= d.
    - d=1: x' = x + (y>>>cnt), y' = y - (x>>>cnt).
    - d=0: x' = x - (y>>>cnt), y' = y + (x>>>cnt).
    - >>> is arithmetic shift with truncation.
    - At cnt==N-1, go to SCALE (macro defined) or DONE.
  - SCALE: mag_reg <= gain-compensated x; go to DONE.
  - DONE: out_valid=1. mag, sigma and quad are held stable while out_ready=0. When out_ready=1, go to IDLE.
- in_ready=0 in every state except IDLE; an in_valid during ITER, SCALE or DONE is ignored and not buffered.
- Latency: out_valid rises N+1 edges after the accepting edge with scaling, N edges without.
- The earliest next accept is the cycle after the DONE handshake.
- x=y=0: every sigma bit = 1 (y>=0), mag=0, quad=0.
- Reset mid-ITER or in DONE: operation aborted, all outputs return to reset values, no partial result is presented.
- mag = final x, which is always >= 0 after quadrant correction.

Optional Feature:
- Macro CORDIC_VEC_SCALE_EN.
- Defined:
  - SCALE state present.
  - mag = (x>>>1) + (x>>>3) - (x>>>6) - (x>>>9), each term truncated, summed at width W. This approximates K≈0.6074.
  - Latency N+1.
- Undefined:
  - No SCALE state; mag = raw x (gain ≈1.6468).
  - Latency N.

Decomposition:
- Package cordic_pkg:
  - state enum {IDLE, ITER, SCALE, DONE}.
  - GUARD_BITS=2.
  - Gain shift constants 1, 3, 6, 9 with signs +, +, -, -.
- Sub-module cordic_gain_comp: combinational shift-add compensator parameterised on width W, instantiated only under CORDIC_VEC_SCALE_EN.

Test Plan (B=14, N=7, macro defined unless stated):
- data_w={4096,0} -> out_valid after 8 edges; mag=4097, sigma=7'b1010001, quad=0.
- Macro undefined, same input -> out_valid after 7 edges; mag=6745, sigma=7'b1010001.
- data_w={-4096,0} -> quad=1, mag=4097, sigma=7'b1010001.
- data_w={3000,4000} -> mag within 5000±8, quad=0. data_w={0,0} -> mag=0, sigma=7'b1111111.
- Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, a second in_valid is ignored; out_ready=1 -> IDLE next edge and the second vector is then accepted.
- Assert rst low at cnt=3 -> outputs zero immediately, in_ready=1. A new vector after release completes with correct results.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared types and constants for the vectoring CORDIC.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    SCALE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Two extra MSBs absorb the CORDIC gain (~1.65 * sqrt(2)) and exact negation of -2^(B-1).
  localparam int GUARD_BITS = 2;

  // Gain compensation K ~= 0.6074 as 2^-1 + 2^-3 - 2^-6 - 2^-9.
  localparam int          GAIN_TERMS = 4;
  localparam int          GAIN_SH [GAIN_TERMS] = '{1, 3, 6, 9};
  localparam logic [3:0]  GAIN_NEG = 4'b1100;  // bit i set: term i is subtracted

endpackage

// File: rtl/cordic_vectoring_if.sv
// Handshake bus of the vectoring CORDIC: input vector and result channels.
interface cordic_vectoring_if #(
  parameter int B = 14,
  parameter int N = 7
) ();
  logic           in_valid;
  logic           in_ready;
  logic [2*B-1:0] data_w;     // {x, y}, two's complement
  logic           out_valid;
  logic           out_ready;
  logic [B+1:0]   mag;
  logic [N-1:0]   sigma;
  logic           quad;

  modport slave (
    input  in_valid, data_w, out_ready,
    output in_ready, out_valid, mag, sigma, quad
  );

  modport master (
    output in_valid, data_w, out_ready,
    input  in_ready, out_valid, mag, sigma, quad
  );
endinterface

// File: rtl/cordic_gain_comp.sv
// Combinational shift-add CORDIC gain compensator, each term truncated, sum kept at width W.
module cordic_gain_comp
  import cordic_pkg::*;
#(
  parameter int W = 16
) (
  input  logic signed [W-1:0] x_in,
  output logic signed [W-1:0] mag_out
);

  // Accumulate the signed shifted terms of K.
  always_comb begin
    mag_out = '0;
    for (int i = 0; i < GAIN_TERMS; i++) begin
      if (GAIN_NEG[i]) mag_out = mag_out - (x_in >>> GAIN_SH[i]);
      else             mag_out = mag_out + (x_in >>> GAIN_SH[i]);
    end
  end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: one micro-rotation per cycle, drives y to zero,
// returns magnitude, direction bits and quadrant flag.
// Optional macro CORDIC_VEC_SCALE_EN adds a SCALE state applying gain compensation.
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int B = 14,
  parameter int N = 7
) (
  input  logic               clk,
  input  logic               rst,   // async, active low
  cordic_vectoring_if.slave  bus
);

  localparam int W  = B + GUARD_BITS;
  localparam int CW = $clog2(N);

  state_t              state, state_nx;
  logic [CW-1:0]       cnt;
  logic signed [W-1:0] x_r, y_r, x_nx, y_nx, x_ext, y_ext, x_ld, y_ld;
  logic                d, neg_in, last;
  logic [W-1:0]        mag_r;
  logic [N-1:0]        sigma_r;
  logic                quad_r;

  assign neg_in = bus.data_w[2*B-1];
  assign x_ext  = {{GUARD_BITS{bus.data_w[2*B-1]}}, bus.data_w[2*B-1:B]};
  assign y_ext  = {{GUARD_BITS{bus.data_w[B-1]}},   bus.data_w[B-1:0]};
  assign x_ld   = neg_in ? -x_ext : x_ext;
  assign y_ld   = neg_in ? -y_ext : y_ext;
  assign last   = (cnt == CW'(N-1));

  // One micro-rotation toward y=0; d=1 when y is non-negative.
  always_comb begin
    d = ~y_r[W-1];
    if (d) begin
      x_nx = x_r + (y_r >>> cnt);
      y_nx = y_r - (x_r >>> cnt);
    end else begin
      x_nx = x_r - (y_r >>> cnt);
      y_nx = y_r + (x_r >>> cnt);
    end
  end

`ifdef CORDIC_VEC_SCALE_EN
  logic signed [W-1:0] x_scaled;

  cordic_gain_comp #(.W(W)) u_gain (
    .x_in    (x_r),
    .mag_out (x_scaled)
  );
`endif

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (bus.in_valid) state_nx = ITER;
`ifdef CORDIC_VEC_SCALE_EN
      ITER:  if (last) state_nx = SCALE;
`else
      ITER:  if (last) state_nx = DONE;
`endif
      SCALE: state_nx = DONE;
      DONE:  if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.mag       = mag_r;
  assign bus.sigma     = sigma_r;
  assign bus.quad      = quad_r;

  // State register and iterative datapath; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      x_r     <= '0;
      y_r     <= '0;
      mag_r   <= '0;
      sigma_r <= '0;
      quad_r  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (bus.in_valid) begin
          x_r    <= x_ld;
          y_r    <= y_ld;
          quad_r <= neg_in;
          cnt    <= '0;
        end
        ITER: begin
          x_r          <= x_nx;
          y_r          <= y_nx;
          sigma_r[cnt] <= d;
          cnt          <= cnt + 1'b1;
`ifndef CORDIC_VEC_SCALE_EN
          if (last) mag_r <= $unsigned(x_nx);
`endif
        end
`ifdef CORDIC_VEC_SCALE_EN
        SCALE: mag_r <= $unsigned(x_scaled);
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Scoreboard bench for cordic_vectoring: reference model pushes expected results at
// each accepted vector; a negedge monitor pops and compares on every result handshake.
module tb_cordic_vectoring;

  localparam int B = 14;
  localparam int N = 7;
`ifdef CORDIC_VEC_SCALE_EN
  localparam int LAT = N + 1;
`else
  localparam int LAT = N;
`endif

  typedef struct {
    int mag;
    int sig;
    int q;
    int acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q_exp[$];

  cordic_vectoring_if #(.B(B), .N(N)) bus ();

  cordic_vectoring #(.B(B), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Floor division by 2^k, i.e. what an arithmetic right shift means numerically.
  function automatic int fdiv(input int a, input int k);
    int p;
    p = 1 << k;
    if (a >= 0) return a / p;
    return -((-a + p - 1) / p);
  endfunction

  // Reference: quadrant fold, N greedy micro-rotations, optional gain multiply-by-sum.
  function automatic exp_t model(input int xi, input int yi);
    exp_t e;
    int x, y, nx, ny;
    x = xi; y = yi; e.q = 0; e.sig = 0;
    if (x < 0) begin x = -x; y = -y; e.q = 1; end
    for (int i = 0; i < N; i++) begin
      if (y >= 0) begin
        e.sig |= (1 << i);
        nx = x + fdiv(y, i); ny = y - fdiv(x, i);
      end else begin
        nx = x - fdiv(y, i); ny = y + fdiv(x, i);
      end
      x = nx; y = ny;
    end
`ifdef CORDIC_VEC_SCALE_EN
    e.mag = fdiv(x, 1) + fdiv(x, 3) - fdiv(x, 6) - fdiv(x, 9);
`else
    e.mag = x;
`endif
    e.acc = 0;
    return e;
  endfunction

  function automatic int sx(input logic [B-1:0] v);
    return int'(signed'(v));
  endfunction

  // Accept detector (scoreboard push) and result monitor.
  logic       prev_ov = 1'b0;
  logic       held = 1'b0;
  int         h_mag, h_sig, h_q;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_ov = 1'b0;
      held    = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        e = model(sx(bus.data_w[2*B-1:B]), sx(bus.data_w[B-1:0]));
        e.acc = cyc + 1;
        q_exp.push_back(e);
      end
      if (bus.out_valid) begin
        if (held) begin
          check("hold_mag",   int'(bus.mag),   h_mag);
          check("hold_sigma", int'(bus.sigma), h_sig);
          check("hold_quad",  int'(bus.quad),  h_q);
          check("hold_in_ready", int'(bus.in_ready), 0);
        end
        if (q_exp.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          if (!prev_ov) check("latency", cyc - q_exp[0].acc, LAT);
          if (bus.out_ready) begin
            e = q_exp.pop_front();
            check("mag",   int'(bus.mag),   e.mag);
            check("sigma", int'(bus.sigma), e.sig);
            check("quad",  int'(bus.quad),  e.q);
          end
        end
        held  = !bus.out_ready;
        h_mag = int'(bus.mag); h_sig = int'(bus.sigma); h_q = int'(bus.quad);
      end else begin
        held = 1'b0;
      end
      prev_ov = bus.out_valid;
    end
  end

  // Present one vector and hold it until accepted (bounded).
  task automatic send(input int x, input int y);
    int t;
    logic [B-1:0] xb, yb;
    xb = x[B-1:0]; yb = y[B-1:0];
    bus.data_w   = {xb, yb};
    bus.in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("accept_timeout", 1, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((q_exp.size() != 0 || !bus.in_ready) && t < 500) begin @(posedge clk); #1; t++; end
    if (t >= 500) check("drain_timeout", 1, 0);
  endtask

  int   dx [6] = '{4096, -4096, 3000, 0, -8192, 8191};
  int   dy [6] = '{0,    0,     4000, 0, -8192, -8192};
  logic rnd_rdy = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rnd_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    int t;
    bus.in_valid = 1'b0; bus.data_w = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_in_ready",  int'(bus.in_ready),  1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_mag",       int'(bus.mag),       0);
    check("rst_sigma",     int'(bus.sigma),     0);
    check("rst_quad",      int'(bus.quad),      0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, including zero and full-scale negative corners.
    for (int i = 0; i < 6; i++) begin
      send(dx[i], dy[i]);
      wait_idle();
    end

    // Back-pressure: hold result 5 cycles while a second vector is offered.
    bus.out_ready = 1'b0;
    send(1234, -2345);
    t = 0;
    while (!bus.out_valid && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) check("hold_wait_timeout", 1, 0);
    bus.data_w = {14'(-700), 14'(5000)};
    bus.in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("hold_queue_depth", q_exp.size(), 1);
    bus.out_ready = 1'b1;
    send(-700, 5000);
    wait_idle();

    // Reset at cnt=3: outputs return to reset values, no partial result.
    send(5555, 3333);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_in_ready",  int'(bus.in_ready),  1);
    check("abort_out_valid", int'(bus.out_valid), 0);
    check("abort_mag",       int'(bus.mag),       0);
    check("abort_sigma",     int'(bus.sigma),     0);
    check("abort_quad",      int'(bus.quad),      0);
    q_exp.delete();
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    send(-3000, 4000);
    wait_idle();

    // Randomized vectors with random result back-pressure.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rnd_rdy = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_idle();
    check("queue_empty", q_exp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
